// File: rtl/witness_player.sv
// witness_player: replays a stored input witness into a design under check and
// reports whether and at which step its target flag fired. Looping replay: WITNESS_LOOP_EN.
module witness_player #(
  parameter int DEPTH   = 64,
  parameter int IW      = 1,
  parameter int CW      = 7,
  parameter int TIMEOUT = 100000
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          load_valid,
  input  logic [IW-1:0] load_data,
  output logic          load_ready,
  input  logic          flush,
  input  logic          start,
  input  logic          clear,
  input  logic          target,
  output logic [IW-1:0] drive,
  output logic          busy,
  output logic          done,
  output logic          hit,
  output logic [CW-1:0] steps,
  output logic [CW-1:0] len,
  output logic          overflow,
  output logic          timed_out,
  output logic [1:0]    state_dbg
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] mem [DEPTH];
  logic [CW-1:0] k;
  logic [CW-1:0] k_nxt;
  logic [CW-1:0] len_upd;
  logic [IW-1:0] first_word;
  logic          store;
  logic          tmo;

  // Load handshake: a word transfers on a posedge with load_valid && load_ready;
  // load_valid while IDLE with storage full drops the word and sets overflow.
  assign load_ready = (state == S_IDLE) && (len < CW'(DEPTH));
  assign store      = load_valid && load_ready && !flush;
  assign k_nxt      = k + CW'(1);
  assign len_upd    = flush ? '0 : (store ? len + CW'(1) : len);
  assign state_dbg  = state;

  // A word stored in the same cycle as start can be the first word replayed.
  always_comb begin
    first_word = mem[0];
    if (len_upd == '0)
      first_word = '0;
    else if (store && (len == '0))
      first_word = load_data;
  end

  always_ff @(posedge clock) begin
    if (store) mem[len[AW-1:0]] <= load_data;
  end

`ifdef WITNESS_LOOP_EN
  logic [31:0] cyc;
  assign timed_out = tmo;
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      len      <= '0;
      k        <= '0;
      drive    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hit      <= 1'b0;
      steps    <= '0;
      overflow <= 1'b0;
      tmo      <= 1'b0;
`ifdef WITNESS_LOOP_EN
      cyc      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          len <= len_upd;
          if (flush)
            overflow <= 1'b0;
          else if (load_valid && !load_ready)
            overflow <= 1'b1;
          if (start) begin
            state <= S_RUN;
            k     <= '0;
            drive <= first_word;
            busy  <= 1'b1;
`ifdef WITNESS_LOOP_EN
            cyc   <= '0;
`endif
          end
        end
        S_RUN: begin
`ifdef WITNESS_LOOP_EN
          cyc <= cyc + 32'd1;
`endif
          if (target) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            drive <= '0;
            hit   <= 1'b1;
            steps <= k;
          end
`ifdef WITNESS_LOOP_EN
          else if (cyc == 32'(TIMEOUT - 1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            drive <= '0;
            hit   <= 1'b0;
            steps <= k;
            tmo   <= 1'b1;
          end else if ((k == len) && (len != '0)) begin
            k     <= '0;
            drive <= mem[0];
          end
`endif
          else if (k == len) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            drive <= '0;
            hit   <= 1'b0;
            steps <= len;
          end else begin
            k     <= k_nxt;
            drive <= (k_nxt < len) ? mem[k_nxt[AW-1:0]] : '0;
          end
        end
        S_DONE: begin
          if (clear) begin
            state <= S_IDLE;
            done  <= 1'b0;
            hit   <= 1'b0;
            tmo   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
